// File: rtl/key_seq_reader_if.sv
// Key-device bus: select strobe, window address, command nibble, read qualifier and serial data.
interface key_seq_reader_if;
    logic       sser_n;
    logic       ba13;
    logic       ba12;
    logic [3:0] ba7_4;
    logic       br_w;
    logic       sdrd;

    modport master (output sser_n, ba13, ba12, ba7_4, br_w, input sdrd);
    modport slave  (input sser_n, ba13, ba12, ba7_4, br_w, output sdrd);
endinterface

// File: rtl/key_seq_reader.sv
// Serial key reader.
// Sends UNLOCK_LEN select strobes that carry the unlock nibbles, then sends
// NBITS read strobes. The key's sdrd bit is captured on each read strobe, MSB
// first. The assembled word is compared against the latched expected value.
module key_seq_reader #(
    parameter int         NBITS      = 16,
    parameter int         UNLOCK_LEN = 4,
    parameter logic [3:0] READ_CODE  = 4'h0,
    parameter int         GAP        = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [4*UNLOCK_LEN-1:0] unlock_seq,
    input  logic [NBITS-1:0]        expected,
    key_seq_reader_if.master        bus,
    output logic                    busy,
    output logic                    done,
    output logic                    match,
    output logic [NBITS-1:0]        key_word
);
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_GAP, S_FIN} state_t;

    state_t                  state;
    logic [4*UNLOCK_LEN-1:0] unlock_q;
    logic [NBITS-1:0]        exp_q;
    logic [2:0]              u_idx;     // unlock nibble being sent
    logic [4:0]              b_idx;     // key bit being read
    logic [3:0]              g_cnt;     // idle cycles spent in GAP
    logic                    rd_phase;  // unlock strobes finished
    logic                    last_q;    // final read strobe done
    logic [3:0]              next_nib;

    // Nibble for the next strobe. The counters have already advanced past the previous strobe.
    always_comb begin
        next_nib = READ_CODE;
        if (!rd_phase)
            next_nib = 4'(unlock_q >> {u_idx, 2'b00});
    end

    // Sequencer: every bus output is registered, so each value appears in the same cycle as its state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            bus.sser_n <= 1'b1;
            bus.ba13  <= 1'b1;
            bus.ba12  <= 1'b0;
            bus.ba7_4 <= 4'h0;
            bus.br_w  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            match     <= 1'b0;
            key_word  <= '0;
            unlock_q  <= '0;
            exp_q     <= '0;
            u_idx     <= '0;
            b_idx     <= '0;
            g_cnt     <= '0;
            rd_phase  <= 1'b0;
            last_q    <= 1'b0;
        end else if (abort && state != S_IDLE) begin
            // Leave the bus idle. The partial key_word stays visible for debug.
            state      <= S_IDLE;
            bus.sser_n <= 1'b1;
            bus.ba13   <= 1'b1;
            bus.ba12   <= 1'b0;
            bus.ba7_4  <= 4'h0;
            bus.br_w   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            match      <= 1'b0;
            u_idx      <= '0;
            b_idx      <= '0;
            g_cnt      <= '0;
            rd_phase   <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    unlock_q  <= unlock_seq;
                    exp_q     <= expected;
                    key_word  <= '0;
                    match     <= 1'b0;
                    busy      <= 1'b1;
                    bus.ba13  <= 1'b0;
                    bus.ba12  <= 1'b1;
                    bus.br_w  <= 1'b1;
                    bus.ba7_4 <= unlock_seq[3:0];
                    u_idx     <= '0;
                    b_idx     <= '0;
                    g_cnt     <= '0;
                    rd_phase  <= 1'b0;
                    last_q    <= 1'b0;
                    state     <= S_SETUP;
                end
                S_SETUP: begin
                    bus.sser_n <= 1'b0;
                    state      <= S_STROBE;
                end
                S_STROBE: begin
                    bus.sser_n <= 1'b1;
                    bus.ba13   <= 1'b1;
                    bus.ba12   <= 1'b0;
                    bus.br_w   <= 1'b0;
                    bus.ba7_4  <= 4'h0;
                    g_cnt      <= '0;
                    state      <= S_GAP;
                    if (rd_phase) begin
                        key_word <= {key_word[NBITS-2:0], bus.sdrd};
                        if (b_idx == 5'(NBITS-1)) last_q <= 1'b1;
                        else                      b_idx  <= b_idx + 5'd1;
                    end else if (u_idx == 3'(UNLOCK_LEN-1)) begin
                        rd_phase <= 1'b1;
                    end else begin
                        u_idx <= u_idx + 3'd1;
                    end
                end
                S_GAP: begin
                    if (g_cnt == 4'(GAP-1)) begin
                        g_cnt <= '0;
                        if (last_q) begin
                            done  <= 1'b1;
                            match <= (key_word == exp_q);
                            state <= S_FIN;
                        end else begin
                            bus.ba13  <= 1'b0;
                            bus.ba12  <= 1'b1;
                            bus.br_w  <= 1'b1;
                            bus.ba7_4 <= next_nib;
                            state     <= S_SETUP;
                        end
                    end else begin
                        g_cnt <= g_cnt + 4'd1;
                    end
                end
                S_FIN: begin
                    done     <= 1'b0;
                    busy     <= 1'b0;
                    u_idx    <= '0;
                    b_idx    <= '0;
                    rd_phase <= 1'b0;
                    last_q   <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_key_seq_reader.sv
// Bench for key_seq_reader: a default instance and a small-parameter instance.
// Each instance talks to a behavioural key model.
module tb_key_seq_reader;
    localparam int U0 = 4, N0 = 16, G0 = 2;
    localparam int U1 = 1, N1 = 8,  G1 = 1;
    localparam logic [3:0] RC = 4'h0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    key_seq_reader_if if0();
    key_seq_reader_if if1();

    logic        start0 = 0, abort0 = 0, busy0, done0, match0;
    logic [15:0] unlock0 = 0, exp0 = 0, kw0;
    logic        start1 = 0, abort1 = 0, busy1, done1, match1;
    logic [3:0]  unlock1 = 0;
    logic [7:0]  exp1 = 0, kw1;

    key_seq_reader u0 (.clk(clk), .rst(rst), .start(start0), .abort(abort0),
        .unlock_seq(unlock0), .expected(exp0), .bus(if0.master),
        .busy(busy0), .done(done0), .match(match0), .key_word(kw0));

    key_seq_reader #(.NBITS(N1), .UNLOCK_LEN(U1), .GAP(G1)) u1 (.clk(clk), .rst(rst),
        .start(start1), .abort(abort1), .unlock_seq(unlock1), .expected(exp1),
        .bus(if1.master), .busy(busy1), .done(done1), .match(match1), .key_word(kw1));

    // Key model. It counts strobes since it was cleared and serves the key bits MSB first once the unlock strobes are over.
    logic [31:0] keyv0 = 0, keyv1 = 0, t0, t1;
    logic        kclr0 = 0, kclr1 = 0;
    int          kcnt0 = 0, kcnt1 = 0;

    always @(posedge clk) if (kclr0) kcnt0 <= 0; else if (!if0.sser_n) kcnt0 <= kcnt0 + 1;
    always @(posedge clk) if (kclr1) kcnt1 <= 0; else if (!if1.sser_n) kcnt1 <= kcnt1 + 1;

    always_comb begin
        t0 = 32'h0;
        if0.sdrd = 1'b0;
        if (kcnt0 >= U0 && kcnt0 < U0 + N0) begin
            t0 = keyv0 >> (N0 - 1 - (kcnt0 - U0));
            if0.sdrd = t0[0];
        end
    end
    always_comb begin
        t1 = 32'h0;
        if1.sdrd = 1'b0;
        if (kcnt1 >= U1 && kcnt1 < U1 + N1) begin
            t1 = keyv1 >> (N1 - 1 - (kcnt1 - U1));
            if1.sdrd = t1[0];
        end
    end

    // View of whichever instance is under test
    int          sel = 0;
    logic        s_sn, s_13, s_12, s_bw, s_bsy, s_dn, s_mt;
    logic [3:0]  s_nib;
    logic [31:0] s_kw;
    always_comb begin
        if (sel == 0) begin
            s_sn = if0.sser_n; s_13 = if0.ba13; s_12 = if0.ba12; s_bw = if0.br_w; s_nib = if0.ba7_4;
            s_bsy = busy0; s_dn = done0; s_mt = match0; s_kw = 32'(kw0);
        end else begin
            s_sn = if1.sser_n; s_13 = if1.ba13; s_12 = if1.ba12; s_bw = if1.br_w; s_nib = if1.ba7_4;
            s_bsy = busy1; s_dn = done1; s_mt = match1; s_kw = 32'(kw1);
        end
    end

    int total = 0, bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic set_ctl(input int s, input logic st, input logic ab);
        if (s == 0) begin start0 = st; abort0 = ab; end
        else        begin start1 = st; abort1 = ab; end
    endtask

    task automatic set_in(input int s, input logic [31:0] ul, input logic [31:0] kv,
                          input logic [31:0] ev, input logic clr);
        if (s == 0) begin unlock0 = ul[15:0]; exp0 = ev[15:0]; keyv0 = kv; kclr0 = clr; end
        else        begin unlock1 = ul[3:0];  exp1 = ev[7:0];  keyv1 = kv; kclr1 = clr; end
    endtask

    // Runs one sequence. Cycle 1 is the cycle after the start cycle.
    task automatic run(input int s, input logic [31:0] ul, input logic [31:0] kv, input logic [31:0] ev,
                       input int restart_at, input int abort_rd,
                       output int n_str, output int done_at, output int n_done,
                       output logic [31:0] kw_done, output logic m_done, output logic [31:0] kw_end,
                       output int bad_nib, output int bad_bus, output int bad_gap);
        int U, G, last_st, ab_cyc;
        logic p_sn, p13, p12, pbw, ab_chk;
        logic [3:0] pnib, want;
        logic [31:0] tmp;
        U = (s == 0) ? U0 : U1;
        G = (s == 0) ? G0 : G1;
        n_str = 0; done_at = -1; n_done = 0; kw_done = 0; m_done = 0; kw_end = 0;
        bad_nib = 0; bad_bus = 0; bad_gap = 0; last_st = -1; ab_cyc = -1; ab_chk = 0;
        sel = s;
        @(negedge clk);
        set_in(s, ul, kv, ev, 1'b1);
        set_ctl(s, 1'b1, 1'b0);
        p_sn = 1; p13 = 1; p12 = 0; pbw = 0; pnib = 0;
        @(negedge clk);
        set_ctl(s, 1'b0, 1'b0);
        set_in(s, ul, kv, ev, 1'b0);
        for (int cyc = 1; cyc <= 400; cyc++) begin
            if (ab_chk) begin
                chk("abort_sser_n", 32'(s_sn), 32'd1);
                chk("abort_busy", 32'(s_bsy), 32'd0);
                ab_chk = 0;
                ab_cyc = cyc;
            end
            if (!s_sn) begin
                tmp  = ul >> (4 * n_str);
                want = (n_str < U) ? tmp[3:0] : RC;
                if (s_nib !== want) bad_nib++;
                if (s_13 !== 1'b0 || s_12 !== 1'b1 || s_bw !== 1'b1) bad_bus++;
                if (p_sn !== 1'b1 || p13 !== 1'b0 || p12 !== 1'b1 || pbw !== 1'b1 || pnib !== s_nib) bad_bus++;
                if (last_st >= 0 && cyc - last_st != 2 + G) bad_gap++;
                last_st = cyc;
                if (abort_rd >= 0 && n_str == U + abort_rd) begin
                    set_ctl(s, 1'b0, 1'b1);
                    ab_chk = 1;
                end
                n_str++;
            end
            if (s_dn === 1'b1) begin
                n_done++;
                if (done_at < 0) begin done_at = cyc; kw_done = s_kw; m_done = s_mt; end
            end
            if (cyc == restart_at) set_ctl(s, 1'b1, ab_chk);
            p_sn = s_sn; p13 = s_13; p12 = s_12; pbw = s_bw; pnib = s_nib;
            kw_end = s_kw;
            if ((done_at >= 0 && cyc >= done_at + 5) || (ab_cyc >= 0 && cyc >= ab_cyc + 120)) break;
            @(negedge clk);
            set_ctl(s, 1'b0, 1'b0);
        end
    endtask

    typedef struct {
        int          s;
        logic [31:0] ul, kv, ev;
        int          strobes, done_at;
        logic [31:0] kw;
        logic        m;
    } vec_t;

    vec_t        tbl[5];
    int          n_str, done_at, n_done, bnib, bbus, bgap;
    logic [31:0] kwd, kwe;
    logic        md;

    task automatic check_run(input string tag, input int strobes, input int dcyc, input int ndone,
                             input logic [31:0] kw, input logic m);
        chk({tag, "_strobes"}, 32'(n_str), 32'(strobes));
        chk({tag, "_done_at"}, 32'(done_at), 32'(dcyc));
        chk({tag, "_ndone"}, 32'(n_done), 32'(ndone));
        chk({tag, "_key_word"}, kwd, kw);
        chk({tag, "_match"}, 32'(md), 32'(m));
        chk({tag, "_nibbles"}, 32'(bnib), 32'd0);
        chk({tag, "_setup"}, 32'(bbus), 32'd0);
        chk({tag, "_spacing"}, 32'(bgap), 32'd0);
    endtask

    initial begin
        tbl[0] = '{0, 32'h9C3A, 32'hB5A1, 32'hB5A1, 20, 81, 32'hB5A1, 1'b1};
        tbl[1] = '{0, 32'h9C3A, 32'hB5A0, 32'hB5A1, 20, 81, 32'hB5A0, 1'b0};
        tbl[2] = '{0, 32'h1234, 32'hFFFF, 32'hFFFF, 20, 81, 32'hFFFF, 1'b1};
        tbl[3] = '{1, 32'h5,    32'h3C,   32'h3C,   9,  28, 32'h3C,   1'b1};
        tbl[4] = '{1, 32'h5,    32'h00,   32'h01,   9,  28, 32'h00,   1'b0};

        // reset, then idle
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        for (int c = 0; c < 10; c++) begin
            for (int s = 0; s < 2; s++) begin
                sel = s;
                #0;
                chk("idle_bus", {21'h0, s_sn, s_13, s_12, s_bw, s_nib, s_bsy, s_dn, s_mt}, 32'b110_0000_0000);
                chk("idle_key_word", s_kw, 32'h0);
            end
            @(negedge clk);
        end

        // table vectors
        foreach (tbl[i]) begin
            run(tbl[i].s, tbl[i].ul, tbl[i].kv, tbl[i].ev, -1, -1,
                n_str, done_at, n_done, kwd, md, kwe, bnib, bbus, bgap);
            check_run($sformatf("vec%0d", i), tbl[i].strobes, tbl[i].done_at, 1, tbl[i].kw, tbl[i].m);
        end

        // abort during the 5th read strobe
        run(0, 32'h9C3A, 32'hB5A1, 32'hB5A1, -1, 4, n_str, done_at, n_done, kwd, md, kwe, bnib, bbus, bgap);
        chk("abort_strobes", 32'(n_str), 32'd9);
        chk("abort_ndone", 32'(n_done), 32'd0);
        chk("abort_partial_kw", kwe, 32'h000B);
        run(0, 32'h9C3A, 32'hB5A1, 32'hB5A1, -1, -1, n_str, done_at, n_done, kwd, md, kwe, bnib, bbus, bgap);
        check_run("after_abort", 20, 81, 1, 32'hB5A1, 1'b1);

        // start while busy
        run(0, 32'h9C3A, 32'hB5A1, 32'hB5A1, 30, -1, n_str, done_at, n_done, kwd, md, kwe, bnib, bbus, bgap);
        check_run("restart_busy", 20, 81, 1, 32'hB5A1, 1'b1);

        // reset in the middle of a strobe
        sel = 0;
        @(negedge clk);
        set_in(0, 32'h9C3A, 32'hB5A1, 32'hB5A1, 1'b1);
        start0 = 1;
        @(negedge clk);
        start0 = 0; kclr0 = 0;
        for (int c = 0; c < 50 && s_sn !== 1'b0; c++) @(negedge clk);
        chk("rst_mid_in_strobe", 32'(s_sn), 32'd0);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("rst_mid_sser_n", 32'(s_sn), 32'd1);
        chk("rst_mid_busy", 32'(s_bsy), 32'd0);
        chk("rst_mid_ba13", 32'(s_13), 32'd1);
        chk("rst_mid_key_word", s_kw, 32'h0);

        // random runs on both instances, checked against the model
        for (int i = 0; i < 8; i++) begin
            int s, U, N, G;
            logic [31:0] ul, kv, ev, mkw, mask;
            s = i % 2;
            U = s ? U1 : U0; N = s ? N1 : N0; G = s ? G1 : G0;
            mask = (32'h1 << N) - 32'h1;
            ul = $urandom;
            kv = $urandom & mask;
            ev = ($urandom_range(0, 1) == 1) ? kv : ($urandom & mask);
            mkw = 0;
            for (int b = N - 1; b >= 0; b--) mkw = ((mkw << 1) | ((kv >> b) & 32'h1)) & mask;
            run(s, ul, kv, ev, -1, -1, n_str, done_at, n_done, kwd, md, kwe, bnib, bbus, bgap);
            check_run($sformatf("rand%0d", i), U + N, (U + N) * (2 + G) + 1, 1, mkw, mkw == ev);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/key_seq_reader.md
Name: key_seq_reader

Overview:
Bus-side initiator for the serial key device that sits in the BA13=0/BA12=1 window. The block issues an unlock sequence of select strobes whose BA7..BA4 nibbles form a command code. It then issues NBITS read strobes, sampling the key's SDRD bit on each one, and assembles the bits into a word. The word is compared against an expected value, and the result is reported to the host controller as done/match.

Parameters:
NBITS, 16, number of key bits read after unlock (2..32)
UNLOCK_LEN, 4, number of unlock strobes (1..8)
READ_CODE, 4'h0, BA7..BA4 nibble driven during read strobes
GAP, 2, idle cycles (sser_n high) between consecutive strobes (1..15)

Ports:
clk  in  1  system clock; all state changes on rising edge
rst  in  1  synchronous reset, active high
start  in  1  one-cycle request to run a full sequence; ignored while busy=1
abort  in  1  terminate current sequence at next edge
unlock_seq  in  4*UNLOCK_LEN  unlock nibbles; nibble 0 = bits [3:0], sent first
expected  in  NBITS  reference key word
sser_n  out  1  key select strobe, active low
ba13  out  1  window address bit, driven 0 whenever sser_n=0
ba12  out  1  window address bit, driven 1 whenever sser_n=0
ba7_4  out  4  command nibble
br_w  out  1  read/write qualifier, driven 1 (read) whenever sser_n=0
sdrd  in  1  serial data bit from key
busy  out  1  sequence in progress
done  out  1  one-cycle pulse at sequence end
match  out  1  key_word==expected, valid from done until next start
key_word  out  NBITS  assembled key bits

Behaviour:
- Reset values (synchronous rst=1 at an edge):
  - sser_n=1, ba13=1, ba12=0, ba7_4=0, br_w=0.
  - busy=0, done=0, match=0, key_word=0.
  - FSM=IDLE, counters=0.
- Bus idle state: when sser_n=1, the block drives ba13=1, ba12=0, br_w=0. The key window is deasserted outside strobes.
- Strobe: sser_n is low for exactly one clk cycle. ba13/ba12/br_w/ba7_4 are driven to their strobe values in that same cycle and held for one setup cycle before it. The key advances on the rising edge that ends the strobe cycle.
- FSM states:
  - IDLE: start=1 → SETUP. Latch unlock_seq and expected. Clear key_word and match. busy=1 from the next cycle.
  - SETUP: 1 cycle. Address lines are driven, sser_n=1. Next state is STROBE.
  - STROBE: 1 cycle, sser_n=0.
    - Unlock phase (unlock index u<UNLOCK_LEN): ba7_4 = latched nibble u; sdrd is ignored.
    - Read phase: ba7_4=READ_CODE; sdrd is sampled at the edge ending the cycle and shifted into key_word LSB (key_word <= {key_word[NBITS-2:0], sdrd}), so the first bit read ends in the MSB.
    - Next state is GAP.
  - GAP: GAP cycles with sser_n=1 and bus at idle values. Then:
    - if more strobes remain → SETUP;
    - otherwise → FIN.
  - FIN: 1 cycle. done=1, match=(key_word==latched expected), busy=0 at the next edge. Next state is IDLE.
- Total strobes: UNLOCK_LEN+NBITS.
- Latency from start to done: (UNLOCK_LEN+NBITS)*(2+GAP)+1 cycles. Defaults: 20*4+1 = 81 cycles.
- Counters:
  - unlock index is 3 bits; bit index is 5 bits.
  - The phase switches from unlock to read when u reaches UNLOCK_LEN. No wrap-around; the counters saturate and are cleared in IDLE.
- abort=1 in any non-IDLE state:
  - Next edge: sser_n=1, bus at idle values, FSM=IDLE, busy=0, done=0, match=0. key_word keeps its partial value.
  - If abort and start are high together in IDLE, start wins and abort is ignored.
- start while busy is ignored and does not restart or extend the sequence.
- rst mid-strobe: sser_n returns to 1 at that edge, and all state goes to reset values.
- If start arrives in the same cycle as FIN, it is ignored; the block must be in IDLE to accept start.
- sdrd is sampled only in read-phase STROBE cycles.

Test Plan:
1. Reset then idle:
   - Stimulus: rst high 2 cycles, then 10 cycles idle.
   - Required response: sser_n=1, ba13=1, ba12=0, br_w=0, busy=0, done=0, key_word=0 throughout.
2. Full default run:
   - Stimulus: unlock_seq=16'h9C3A, expected=16'hB5A1; the bench model drives sdrd bits of 0xB5A1 MSB-first on read strobes; pulse start.
   - Required response:
     - exactly 20 sser_n low pulses;
     - ba7_4 sequence A,3,C,9 then 0 ×16;
     - done pulses at cycle 81 after start;
     - key_word=16'hB5A1, match=1.
3. Mismatch:
   - Stimulus: same as scenario 2, but the model drives 0xB5A0.
   - Required response: key_word=16'hB5A0, match=0, done pulses once.
4. Abort mid-read:
   - Stimulus: assert abort during the 5th read strobe.
   - Required response: next cycle sser_n=1, busy=0, no done pulse; a subsequent start runs the full 20 strobes.
5. start while busy:
   - Stimulus: pulse start again at cycle 30.
   - Required response: strobe count and done timing are identical to scenario 2.
6. Parameter sweep:
   - Stimulus: NBITS=8, UNLOCK_LEN=1, GAP=1, unlock_seq=4'h5, model drives 0x3C.
   - Required response: 9 strobes, each 3 cycles apart; done at cycle 28; key_word=8'h3C.
